// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and baud helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Clocks per bit, truncated; the transmitter derives its bit timing the same way.
    function automatic int uart_bit_cnt(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser and falling-edge detector for the rx line
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic rx_s1;
    logic rx_s2;
    logic rx_s3;

    // Flops reset to the idle level so a line already low at reset release reads as a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_sync = rx_s2;
    assign rx_fall = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_rx_decode.sv
// rtl/uart_rx_decode.sv - UART receiver: start detect, mid-bit sampling, byte strobe; parity via UART_PARITY_EN
module uart_rx_decode
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int BIT_CNT    = uart_bit_cnt(CLK_FREQ, BAUD_RATE),
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    output logic       data_out_flag,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int                CNT_W     = $clog2(BIT_CNT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

    generate
        if (BIT_CNT < 4) begin : g_bad_bit_cnt
            $error("uart_rx_decode: BIT_CNT must be at least 4");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
            $error("uart_rx_decode: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    logic rx_s2;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (uart_rx),
        .rx_sync (rx_s2),
        .rx_fall (rx_fall)
    );

    uart_state_t               state_q,    state_d;
    logic [CNT_W-1:0]          baud_cnt_q, baud_cnt_d;
    logic [2:0]                bit_idx_q,  bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
    logic [7:0]                data_q,     data_d;
    logic                      flag_q,     flag_d;
    logic                      ferr_q,     ferr_d;
`ifdef UART_PARITY_EN
    localparam logic PAR_SENSE = 1'(PARITY_ODD);
    logic                      par_bad_q,  par_bad_d;
    logic                      perr_q,     perr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            flag_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            flag_q     <= flag_d;
            ferr_q     <= ferr_d;
`ifdef UART_PARITY_EN
            par_bad_q  <= par_bad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        flag_d     = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d  = par_bad_q;
        perr_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (rx_fall) begin
                    state_d = START;
                end
            end

            // Re-check the start bit at its centre; a high sample means the edge was a glitch.
            START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = rx_s2 ? IDLE : DATA;
                end
            end

            DATA: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s2, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_PARITY_EN
            PARITY: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    par_bad_d  = rx_s2 ^ (^shift_q) ^ PAR_SENSE;
                    state_d    = STOP;
                end
            end
`endif

            // Leave for IDLE on the stop sample itself so a start bit right after is still caught.
            STOP: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    if (!rx_s2) begin
                        ferr_d = 1'b1;
`ifdef UART_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        flag_d = 1'b1;
                        data_d = shift_q;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    assign data_out      = data_q;
    assign data_out_flag = flag_q;
    assign frame_err     = ferr_q;
    assign rx_busy       = (state_q != IDLE);
`ifdef UART_PARITY_EN
    assign parity_err    = perr_q;
`else
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_decode.sv
// tb/tb_uart_rx_decode.sv - self-checking bench for uart_rx_decode, default 8N1 or with UART_PARITY_EN
module tb_uart_rx_decode;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int BC        = CLK_FREQ / BAUD_RATE;
    localparam int P         = 10;
`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_BITS = 10 + PARITY_BITS;
    localparam int LAT        = 3 + BC / 2 + (FRAME_BITS - 1) * BC;

    localparam int K_FLAG = 1;
    localparam int K_FERR = 2;
    localparam int K_PERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     t;
    } evt_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         gap;
        int         exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] data_out;
    logic       data_out_flag;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    int         tests;
    int         fails;
    int         busy_cnt;
    int         overlap_cnt;
    int         got_rd;
    evt_t       got_q[$];
    evt_t       exp_q[$];
    logic [7:0] last_good;

    uart_rx_decode #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .PARITY_ODD (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx       (uart_rx),
        .data_out      (data_out),
        .data_out_flag (data_out_flag),
        .frame_err     (frame_err),
        .parity_err    (parity_err),
        .rx_busy       (rx_busy)
    );

    initial clk = 1'b0;
    always #(P / 2) clk = ~clk;

    // Event recorder; event time is the negedge at which the strobe is seen.
    always @(negedge clk) begin : monitor
        evt_t e;
        if (!rst) begin
            if (int'(data_out_flag) + int'(frame_err) + int'(parity_err) > 1) overlap_cnt++;
            if (rx_busy) busy_cnt++;
            e.data = data_out;
            e.t    = longint'($time);
            if (data_out_flag) begin e.kind = K_FLAG; got_q.push_back(e); end
            if (frame_err)     begin e.kind = K_FERR; got_q.push_back(e); end
            if (parity_err)    begin e.kind = K_PERR; got_q.push_back(e); end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop,
                              output longint t0);
        logic par_bit;
        par_bit = par_ok ? (^b) : ~(^b);
        t0 = longint'($time);
        hold(1'b0, BC);
        for (int i = 0; i < 8; i++) hold(b[i], BC);
        if (PARITY_BITS != 0) hold(par_bit, BC);
        hold(stop, BC);
    endtask

    // Reference: one event per frame, LAT cycles after the start bit is driven.
    task automatic expect_frame(input logic [7:0] b, input logic par_ok, input logic stop,
                                input longint t0);
        evt_t e;
        e.t = t0 + longint'(LAT * P);
        if (!stop) begin
            e.kind = K_FERR;
            e.data = last_good;
        end else if (!par_ok) begin
            e.kind = K_PERR;
            e.data = last_good;
        end else begin
            e.kind    = K_FLAG;
            e.data    = b;
            last_good = b;
        end
        exp_q.push_back(e);
    endtask

    task automatic check_events(input string name);
        int n;
        n = got_q.size() - got_rd;
        chk($sformatf("%s count", name), n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d] kind", name, i), got_q[got_rd + i].kind, exp_q[i].kind);
            chk($sformatf("%s[%0d] data", name, i), got_q[got_rd + i].data, exp_q[i].data);
            chk($sformatf("%s[%0d] cycle", name, i), got_q[got_rd + i].t / P, exp_q[i].t / P);
        end
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        vec_t       vecs[5];
        longint     tv[5];
        longint     t0;
        int         b0;
        int         gap;
        logic [7:0] b;
        logic       stop;
        logic       par_ok;

        tests = 0; fails = 0; busy_cnt = 0; overlap_cnt = 0; got_rd = 0;
        last_good = 8'h00;

        vecs[0] = '{8'hA5, 1'b1, 20, K_FLAG, 8'hA5};
        vecs[1] = '{8'h00, 1'b1,  0, K_FLAG, 8'h00};
        vecs[2] = '{8'hFF, 1'b1,  0, K_FLAG, 8'hFF};
        vecs[3] = '{8'h3C, 1'b0, 20, K_FERR, 8'hFF};
        vecs[4] = '{8'h81, 1'b1,  5, K_FLAG, 8'h81};

        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_out", data_out, 8'h00);
        chk("reset flag", data_out_flag, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset parity_err", parity_err, 0);
        chk("reset rx_busy", rx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 10);

        // Table vectors, including the back-to-back 00/FF pair and a bad stop bit.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].b, 1'b1, vecs[i].stop, t0);
            tv[i] = t0;
            hold(1'b1, vecs[i].gap);
        end
        hold(1'b1, 30);
        chk("table count", got_q.size() - got_rd, 5);
        if (got_q.size() - got_rd == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("table[%0d] kind", i), got_q[got_rd + i].kind, vecs[i].exp_kind);
                chk($sformatf("table[%0d] data", i), got_q[got_rd + i].data, vecs[i].exp_data);
                chk($sformatf("table[%0d] latency", i), (got_q[got_rd + i].t - tv[i]) / P, LAT);
            end
            chk("back-to-back spacing", (got_q[got_rd + 2].t - got_q[got_rd + 1].t) / P,
                FRAME_BITS * BC);
        end
        got_rd = got_q.size();
        for (int i = 0; i < 5; i++) if (vecs[i].exp_kind == K_FLAG) last_good = vecs[i].exp_data;

        // Three-cycle low glitch on an idle line.
        b0 = busy_cnt;
        hold(1'b0, 3);
        hold(1'b1, 30);
        chk("glitch busy within 9", int'(busy_cnt - b0 >= 1 && busy_cnt - b0 <= 9), 1);
        chk("glitch rx_busy idle", rx_busy, 0);
        check_events("glitch");
        chk("glitch data_out kept", data_out, last_good);

        // Bad stop bit then break: exactly one frame error.
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        expect_frame(8'h3C, 1'b1, 1'b0, t0);
        hold(1'b0, 300);
        hold(1'b1, 30);
        check_events("break");
        chk("break data_out kept", data_out, last_good);

        // Reset 40 cycles into a frame.
        hold(1'b0, BC);
        hold(1'b1, BC);
        hold(1'b0, BC);
        hold(1'b1, BC);
        rst = 1'b1;
        uart_rx = 1'b1;
        #1;
        chk("midreset data_out", data_out, 8'h00);
        chk("midreset flag", data_out_flag, 0);
        chk("midreset frame_err", frame_err, 0);
        chk("midreset parity_err", parity_err, 0);
        chk("midreset rx_busy", rx_busy, 0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        hold(1'b1, 5);
        check_events("midreset no strobe");
        send_frame(8'h5A, 1'b1, 1'b1, t0);
        expect_frame(8'h5A, 1'b1, 1'b1, t0);
        hold(1'b1, 30);
        check_events("after reset");

`ifdef UART_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1, t0);
        expect_frame(8'h07, 1'b0, 1'b1, t0);
        hold(1'b1, 20);
        send_frame(8'h07, 1'b1, 1'b1, t0);
        expect_frame(8'h07, 1'b1, 1'b1, t0);
        hold(1'b1, 30);
        check_events("parity");
`endif

        // Random frames against the reference.
        for (int i = 0; i < 20; i++) begin
            b      = 8'($urandom);
            stop   = ($urandom_range(0, 4) != 0);
            par_ok = (PARITY_BITS == 0) || ($urandom_range(0, 4) != 0);
            gap    = $urandom_range(0, 15);
            if (!stop && gap == 0) gap = 1;
            send_frame(b, par_ok, stop, t0);
            expect_frame(b, par_ok, stop, t0);
            hold(1'b1, gap);
        end
        hold(1'b1, 30);
        check_events("random");
        chk("random data_out", data_out, last_good);

        chk("strobe overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
